// File: rtl/pcie_fifo_pkg.sv
// Shared constants for the transmit-layer lane FIFOs: default geometry and
// the bit positions used when packing FIFO status onto the lane status bus.
package pcie_fifo_pkg;

    localparam int unsigned DefDataWidth = 6;
    localparam int unsigned DefAddrWidth = 2;

    localparam int unsigned StatusFull        = 0;
    localparam int unsigned StatusEmpty       = 1;
    localparam int unsigned StatusAlmostFull  = 2;
    localparam int unsigned StatusAlmostEmpty = 3;
    localparam int unsigned StatusOverflow    = 4;
    localparam int unsigned StatusUnderflow   = 5;
    localparam int unsigned StatusWidth       = 6;

    function automatic logic [StatusWidth-1:0] pack_status(
        input logic full,
        input logic empty,
        input logic almost_full,
        input logic almost_empty,
        input logic overflow,
        input logic underflow
    );
        logic [StatusWidth-1:0] s;
        s                    = '0;
        s[StatusFull]        = full;
        s[StatusEmpty]       = empty;
        s[StatusAlmostFull]  = almost_full;
        s[StatusAlmostEmpty] = almost_empty;
        s[StatusOverflow]    = overflow;
        s[StatusUnderflow]   = underflow;
        return s;
    endfunction

endpackage

// File: rtl/pcie_fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH register array with one write port and one
// registered read port. The storage itself is never reset; only the read register is.
module pcie_fifo_mem
    import pcie_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [Depth];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value when no pop is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pcie_fifo_param.sv
// Parametrised synchronous lane FIFO: guarded push/pop, sticky overflow/underflow
// errors, occupancy count and threshold flags derived combinationally from count.
module pcie_fifo_param
    import pcie_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_enable,
    input  logic                  rd_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH:0]   th_almost_empty,
    input  logic [ADDR_WIDTH:0]   th_almost_full,
    input  logic                  err_clear,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full_fifo,
    output logic                  empty_fifo,
    output logic                  almost_full_fifo,
    output logic                  almost_empty_fifo,
    output logic                  error_overflow,
    output logic                  error_underflow
);

    localparam logic [ADDR_WIDTH:0] DepthCnt = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  valid_q;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  push_ok, pop_ok;

    assign empty_fifo        = (count_q == '0);
    assign full_fifo         = (count_q == DepthCnt);
    assign almost_empty_fifo = (count_q <= th_almost_empty);
    // A margin larger than the depth would underflow the subtraction; saturate instead.
    assign almost_full_fifo  = (th_almost_full > DepthCnt) ? 1'b1
                             : (count_q >= (DepthCnt - th_almost_full));

    always_comb begin
        pop_ok   = rd_enable & ~empty_fifo;
        // No bypass: a pop on empty is rejected even with a concurrent push.
        push_ok  = wr_enable & (~full_fifo | pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
        // A new fault wins over a concurrent clear.
        ovf_d = (wr_enable & ~push_ok) ? 1'b1 : (err_clear ? 1'b0 : ovf_q);
        udf_d = (rd_enable & ~pop_ok)  ? 1'b1 : (err_clear ? 1'b0 : udf_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= pop_ok;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    pcie_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (push_ok),
        .wr_addr(wr_ptr_q),
        .wr_data(data_in),
        .rd_en  (pop_ok),
        .rd_addr(rd_ptr_q),
        .rd_data(data_out)
    );

    assign data_out_valid  = valid_q;
    assign count           = count_q;
    assign error_overflow  = ovf_q;
    assign error_underflow = udf_q;

endmodule

// File: tb/tb_pcie_fifo_param.sv
// Scoreboard bench for pcie_fifo_param: directed pushes/pops queue hand-computed
// pop words; a negedge monitor checks every data_out_valid beat against the queue.
module tb_pcie_fifo_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_enable, rd_enable, err_clear;
    logic [5:0] data_in;
    logic [2:0] th_almost_empty, th_almost_full;
    logic [5:0] data_out;
    logic       data_out_valid;
    logic [2:0] count;
    logic       full_fifo, empty_fifo, almost_full_fifo, almost_empty_fifo;
    logic       error_overflow, error_underflow;

    int vectors = 0;
    int miscompares = 0;
    logic [5:0] exp_q [$];

    pcie_fifo_param #(
        .DATA_WIDTH(6),
        .ADDR_WIDTH(2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .wr_enable        (wr_enable),
        .rd_enable        (rd_enable),
        .data_in          (data_in),
        .th_almost_empty  (th_almost_empty),
        .th_almost_full   (th_almost_full),
        .err_clear        (err_clear),
        .data_out         (data_out),
        .data_out_valid   (data_out_valid),
        .count            (count),
        .full_fifo        (full_fifo),
        .empty_fifo       (empty_fifo),
        .almost_full_fifo (almost_full_fifo),
        .almost_empty_fifo(almost_empty_fifo),
        .error_overflow   (error_overflow),
        .error_underflow  (error_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; an accepted pop queues its hand-computed word.
    task automatic op(input logic wr, input logic rd, input logic [5:0] din,
                      input logic clr, input logic pop_exp, input logic [5:0] pop_word);
        wr_enable = wr;
        rd_enable = rd;
        data_in   = din;
        err_clear = clr;
        if (pop_exp) exp_q.push_back(pop_word);
        @(posedge clk);
        #1;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        err_clear = 1'b0;
    endtask

    // Monitor: every valid beat must match the oldest expected word.
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (data_out_valid === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_pop: data_out=%0h with no word expected", data_out);
                end else begin
                    e = exp_q.pop_front();
                    if (data_out !== e) begin
                        miscompares++;
                        $display("FAIL pop_data: got %0h, expected %0h", data_out, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        err_clear = 1'b0;
        data_in = '0;
        th_almost_empty = 3'd1;
        th_almost_full = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_count", count, 0);
        check("rst_empty", empty_fifo, 1);
        check("rst_full", full_fifo, 0);
        check("rst_data_out", data_out, 0);
        check("rst_valid", data_out_valid, 0);
        check("rst_ovf", error_overflow, 0);
        check("rst_udf", error_underflow, 0);
        check("rst_almost_empty", almost_empty_fifo, 1);
        check("rst_almost_full", almost_full_fifo, 0);

        // Fill, then overflow
        for (int i = 1; i <= 4; i++) op(1, 0, 6'(i), 0, 0, '0);
        check("fill_full", full_fifo, 1);
        check("fill_count", count, 4);
        op(1, 0, 6'h05, 0, 0, '0);
        check("ovf_set", error_overflow, 1);
        check("ovf_count", count, 4);
        op(0, 0, '0, 1, 0, '0);
        check("ovf_cleared", error_overflow, 0);
        for (int i = 1; i <= 4; i++) op(0, 1, '0, 0, 1, 6'(i));
        check("drain_empty", empty_fifo, 1);
        check("drain_udf", error_underflow, 0);

        // Interleaved traffic at occupancy 2 across pointer wrap
        op(1, 0, 6'h10, 0, 0, '0);
        op(1, 0, 6'h11, 0, 0, '0);
        for (int i = 0; i < 8; i++) begin
            op(1, 1, 6'h12 + 6'(i), 0, 1, 6'h10 + 6'(i));
            check("wrap_count", count, 2);
        end
        op(0, 1, '0, 0, 1, 6'h18);
        op(0, 1, '0, 0, 1, 6'h19);
        check("wrap_ovf", error_overflow, 0);
        check("wrap_udf", error_underflow, 0);
        check("wrap_empty", empty_fifo, 1);

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) op(1, 0, 6'h20 + 6'(i), 0, 0, '0);
        op(1, 1, 6'h2A, 0, 1, 6'h20);
        check("fullpp_count", count, 4);
        check("fullpp_full", full_fifo, 1);
        check("fullpp_ovf", error_overflow, 0);
        op(0, 1, '0, 0, 1, 6'h21);
        op(0, 1, '0, 0, 1, 6'h22);
        op(0, 1, '0, 0, 1, 6'h23);
        op(0, 1, '0, 0, 1, 6'h2A);

        // Empty with simultaneous push and pop: no bypass
        op(1, 1, 6'h15, 0, 0, '0);
        check("emptypp_udf", error_underflow, 1);
        check("emptypp_valid", data_out_valid, 0);
        check("emptypp_count", count, 1);
        check("emptypp_data_held", data_out, 6'h2A);
        op(0, 1, '0, 0, 1, 6'h15);
        // Clear concurrent with a new underflow: set wins
        op(0, 1, '0, 1, 0, '0);
        check("udf_set_wins", error_underflow, 1);
        op(0, 0, '0, 1, 0, '0);
        check("udf_cleared", error_underflow, 0);

        // Thresholds: almost_empty at 0,1; almost_full at 3,4
        th_almost_full = 3'd5;
        #1;
        check("af_saturate", almost_full_fifo, 1);
        th_almost_full = 3'd1;
        #1;
        check("th_c0_af", almost_full_fifo, 0);
        for (int i = 1; i <= 4; i++) begin
            op(1, 0, 6'h30 + 6'(i), 0, 0, '0);
            check("th_ae", almost_empty_fifo, (i <= 1) ? 1 : 0);
            check("th_af", almost_full_fifo, (i >= 3) ? 1 : 0);
        end
        op(0, 1, '0, 0, 1, 6'h31);
        check("th_c3_count", count, 3);

        // Reset mid-operation discards queued words
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst2_count", count, 0);
        check("rst2_empty", empty_fifo, 1);
        check("rst2_data_out", data_out, 0);
        check("rst2_valid", data_out_valid, 0);
        op(0, 1, '0, 0, 0, '0);
        check("rst2_pop_udf", error_underflow, 1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
